imem_stream_loader: RTL and testbench

//  Write-side counterpart of the core's instruction fetch path: accepts a byte stream from a host/bench
//  and writes it as 32-bit words into instruction memory, holding the core in reset while loading.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_byte_packer.sv | 35 +++
 rtl/imem_stream_loader.sv | 140 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

    localparam int unsigned IMEM_WORD_W    = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler: gathers four bytes and presents the word
// combinationally alongside the fourth byte so the caller can register it.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [BYTE_W-1:0]      byte_data,
    output logic                   word_valid_c,
    output logic [IMEM_WORD_W-1:0] word_c
);

    localparam int unsigned LANE_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned SHIFT_W = IMEM_WORD_W - BYTE_W;

    logic [LANE_W-1:0]  lane;
    logic [SHIFT_W-1:0] shift;

    assign word_valid_c = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word_c       = {byte_data, shift};

    // Earlier bytes slide toward the LSB so byte 0 ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane  <= '0;
            shift <= '0;
        end else if (byte_valid) begin
            lane  <= lane + LANE_W'(1);
            shift <= {byte_data, shift[SHIFT_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core in reset
// until a clean load completes. Define CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [BYTE_W-1:0]      s_data,
    output logic                   s_ready,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [IMEM_WORD_W-1:0] imem_wdata,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [LEN_W-1:0]       words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = LEN_W + 2;

`ifdef CHECKSUM_EN
    localparam loader_state_e POST_DATA = CSUM;
`else
    localparam loader_state_e POST_DATA = DONE;
`endif

    loader_state_e state, state_nx;

    logic [BYTE_W-1:0]      len_lo;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       hdr_len;
    logic [CNT_W-1:0]       byte_cnt;
    logic [CNT_W-1:0]       total_bytes;
    logic                   accept;
    logic                   data_acc;
    logic                   last_byte;
    logic                   start_ok;
    logic                   word_valid_c;
    logic [IMEM_WORD_W-1:0] word_c;
`ifdef CHECKSUM_EN
    logic [BYTE_W-1:0]      csum;
`endif

    assign accept      = s_valid && s_ready;
    assign data_acc    = accept && (state == DATA);
    assign hdr_len     = LEN_W'({s_data, len_lo});
    assign total_bytes = {len_q, 2'b00};
    assign last_byte   = (byte_cnt == total_bytes - CNT_W'(1));
    assign start_ok    = start && (state inside {IDLE, DONE, ERR});

    imem_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_ok),
        .byte_valid   (data_acc),
        .byte_data    (s_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state decode; an oversize header is rejected before any payload arrives.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
            LEN_LO:          if (accept) state_nx = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (32'(hdr_len) > DEPTH)  state_nx = ERR;
                    else if (hdr_len == '0)    state_nx = POST_DATA;
                    else                       state_nx = DATA;
                end
            end
            DATA:            if (data_acc && last_byte) state_nx = POST_DATA;
`ifdef CHECKSUM_EN
            CSUM:            if (accept) state_nx = (s_data == csum) ? DONE : ERR;
`endif
            default:         state_nx = IDLE;
        endcase
    end

    // State, status outputs (decoded from the next state) and imem port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            core_reset   <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            len_lo       <= '0;
            len_q        <= '0;
        end else begin
            state      <= state_nx;
            s_ready    <= state_nx inside {LEN_LO, LEN_HI, DATA, CSUM};
            busy       <= state_nx inside {LEN_LO, LEN_HI, DATA, CSUM};
            done       <= (state_nx == DONE);
            error      <= (state_nx == ERR);
            core_reset <= (state_nx != DONE);
            imem_we    <= word_valid_c;
            if (word_valid_c) imem_wdata <= word_c;

            if (start_ok) begin
                imem_addr    <= '0;
                words_loaded <= '0;
                byte_cnt     <= '0;
            end else begin
                if (imem_we) begin
                    imem_addr    <= imem_addr + ADDR_W'(1);
                    words_loaded <= words_loaded + LEN_W'(1);
                end
                if (data_acc) byte_cnt <= byte_cnt + CNT_W'(1);
            end

            if (accept && state == LEN_LO) len_lo <= s_data;
            if (accept && state == LEN_HI) len_q  <= hdr_len;
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR over payload bytes only; header bytes are not covered.
    always_ff @(posedge clk) begin
        if (reset || start_ok) csum <= '0;
        else if (data_acc)     csum <= csum ^ s_data;
    end
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: table of load frames plus mid-load reset
// and start-while-busy sequences; imem writes are checked against a scoreboard queue.
module tb_imem_stream_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NVEC   = 7;

`ifdef CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] n;
        int          kind;
        bit          gaps;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  words_loaded;

    int          total = 0;
    int          bad   = 0;
    wr_t         sb[$];
    vec_t        vecs[NVEC];
    logic [31:0] rand8[8];

    imem_stream_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    function automatic logic [31:0] get_word(input int kind, input int i);
        case (kind)
            0:       return (i == 0) ? 32'h0000_0013 : 32'h0050_0093;
            1:       return rand8[i];
            2:       return 32'h4433_2211;
            default: return 32'(i) * 32'h9E37_79B1;
        endcase
    endfunction

    // Called on a negedge; returns on the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        while (s_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got s_ready %b want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"},      32'(s_ready),      32'd0);
        check({tag, "_imem_we"},      32'(imem_we),      32'd0);
        check({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
        check({tag, "_imem_wdata"},   imem_wdata,        32'd0);
        check({tag, "_core_reset"},   32'(core_reset),   32'd1);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic run_load(input vec_t v);
        logic [7:0]  csum;
        logic [31:0] w;
        csum = 8'h00;
        // A byte offered in the start cycle must not be taken.
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        check("start_ready",      32'(s_ready),      32'd1);
        check("start_busy",       32'(busy),         32'd1);
        check("start_core_reset", 32'(core_reset),   32'd1);
        check("start_words",      32'(words_loaded), 32'd0);
        send_byte(v.n[7:0], v.gaps);
        send_byte(v.n[15:8], v.gaps);
        if (32'(v.n) <= DEPTH) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = get_word(v.kind, i);
                sb.push_back('{addr: ADDR_W'(i), data: w});
                for (int b = 0; b < 4; b++) begin
                    send_byte(w[8*b +: 8], v.gaps);
                    csum = csum ^ w[8*b +: 8];
                end
            end
            if (CSUM_EN) send_byte(v.bad_csum ? (csum ^ 8'h01) : csum, v.gaps);
        end
        check("end_done",       32'(done),       32'(v.exp_done));
        check("end_error",      32'(error),      32'(v.exp_err));
        check("end_core_reset", 32'(core_reset), 32'(!v.exp_done));
        check("end_busy",       32'(busy),       32'd0);
        check("end_ready",      32'(s_ready),    32'd0);
        repeat (2) @(negedge clk);
        check("end_words",      32'(words_loaded), 32'(v.exp_words));
        check("end_sb_empty",   32'(sb.size()),    32'd0);
    endtask

    // Reset lands after five payload bytes; the first word is already written.
    task automatic mid_load_reset();
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{addr: '0, data: w});
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 32'(busy),    32'd1);
        check("busy_start_ready",   32'(s_ready), 32'd1);
        send_byte(8'h77, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) rand8[i] = $urandom;
        vecs[0] = '{n: 16'd2,                  kind: 0, gaps: 0, bad_csum: 0, exp_done: 1,        exp_err: 0,       exp_words: 2};
        vecs[1] = '{n: 16'd0,                  kind: 0, gaps: 0, bad_csum: 0, exp_done: 1,        exp_err: 0,       exp_words: 0};
        vecs[2] = '{n: 16'(DEPTH + 1),         kind: 0, gaps: 0, bad_csum: 0, exp_done: 0,        exp_err: 1,       exp_words: 0};
        vecs[3] = '{n: 16'd8,                  kind: 1, gaps: 1, bad_csum: 0, exp_done: 1,        exp_err: 0,       exp_words: 8};
        vecs[4] = '{n: 16'd8,                  kind: 1, gaps: 0, bad_csum: 0, exp_done: 1,        exp_err: 0,       exp_words: 8};
        vecs[5] = '{n: 16'd1,                  kind: 2, gaps: 0, bad_csum: 1, exp_done: !CSUM_EN, exp_err: CSUM_EN, exp_words: 1};
        vecs[6] = '{n: 16'(DEPTH),             kind: 3, gaps: 0, bad_csum: 0, exp_done: 1,        exp_err: 0,       exp_words: int'(DEPTH)};

        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(s_ready), 32'd0);

        for (int i = 0; i < int'(NVEC); i++) run_load(vecs[i]);
        mid_load_reset();
        check("idle_ready_after_rst", 32'(s_ready), 32'd0);
        run_load(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
